fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the RV32I pipeline. It supersedes the combinational fetch path: it drives a synchronous, 1-cycle-latency instruction memory and buffers fetched words in a small instruction queue. It accepts redirects from EX and back-pressure from the hazard unit. The head entry is presented to the IF/ID register as an `ifid_t`; optional static branch prediction is compiled in by macro.

## Interface
Parameters:
- XLEN, 32, datapath width
- ADDR_WIDTH, 8, imem byte-address bits taken from PC
- FIFO_DEPTH, 4, instruction-queue entries; power of two, ≥2
- RESET_PC, 0, PC loaded on reset

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  EX redirect (taken branch/jump, mispredict)
- redirect_pc  in  XLEN  redirect target
- id_ready  in  1  ID accepts head entry this cycle (≈ !StallD)
- imem_req  out  1  read issued this cycle
- imem_addr  out  ADDR_WIDTH  PC[ADDR_WIDTH-1:0] of issued read
- imem_rdata  in  32  instruction; valid the cycle after imem_req
- out_valid  out  1  queue head valid
- outputs  out  ifid_t  head entry: PC, PCPlus4, instr, pred_taken
- PCPlus4F  out  XLEN  fetch PC + 4 (current request PC)

## Operation
- State: fetch PC, 1-bit in-flight flag plus in-flight PC, 1-bit squash flag, queue (count 0..FIFO_DEPTH).
- Issue: imem_req = !reset && !redirect_valid && (count + inflight) < FIFO_DEPTH. On issue: in-flight ← 1, in-flight PC ← PC, PC ← PC + 4.
- Response: in the cycle after an issue, if the squash flag is clear, push {in-flight PC, in-flight PC + 4, imem_rdata, pred}. If the squash flag is set, drop the response and clear the flag.
- Pop: when out_valid && id_ready. Push and pop may occur in the same cycle, including at full or empty. The credit rule means a push never hits a full queue.
- Redirect (priority over everything): queue cleared, PC ← redirect_pc, an in-flight response in the same cycle is dropped, no pop and no issue that cycle.
- Arithmetic: PC + 4 wraps modulo 2^XLEN. imem_addr truncates PC.
- Outputs with out_valid=0: contents don't-care, driven from the head slot.

## Timing
- Reset values: PC = RESET_PC, count = 0, in-flight = 0, squash = 0, out_valid = 0, imem_req = 0 while reset is high, pred_taken = 0.
- Latency: issue in cycle C; imem_rdata in C+1 and pushed at the end of C+1; out_valid in C+2.
- Redirect in cycle R: first issue to redirect_pc in R+1; out_valid in R+3.
- Steady state with id_ready=1: one instruction per cycle after the 2-cycle fill.
- id_ready=0: issue continues until count + inflight = FIFO_DEPTH, then imem_req=0. Throughput resumes the cycle after pops free credit.
- Reset asserted mid-operation: all state returns to reset values at that edge. The response to a pre-reset request is ignored.

## Configuration
- FETCH_BTFN_EN defined: the response is predecoded in C+1.
  - JAL (opcode 1101111) is always predicted taken.
  - B-type (1100011) is predicted taken when instr[31]=1 (backward).
  - Target = in-flight PC + sign-extended J/B immediate. PC ← target, the squash flag is set to kill the C+1 request, and the entry gets pred_taken=1.
  - Cost: one bubble per predicted-taken instruction.
  - External redirect in the same cycle overrides the prediction (PC ← redirect_pc, entry dropped).
- FETCH_BTFN_EN undefined: purely sequential fetch; pred_taken tied to 0; no predecode logic.

## Structure
- pipeline_pkg: ifid_t gains a `pred_taken` bit. Add opcode constants OP_JAL / OP_BRANCH.
- Sub-module fetch_fifo: parametrised XLEN/FIFO_DEPTH circular buffer with push, pop and clear; it holds ifid_t entries. Pointers wrap modulo FIFO_DEPTH.
- fetch_unit owns the PC, credit, squash and predecode logic.

## Test plan
- Reset, RESET_PC=0x0, id_ready=1, sequential imem → imem_addr 0x0, 0x4, 0x8… on consecutive cycles; out_valid first high 2 cycles after the first issue; PCs 0x0, 0x4… once per cycle.
- id_ready=0 from reset, FIFO_DEPTH=4 → exactly 4 issues, then imem_req=0, count=4. Raise id_ready → pop one entry per cycle and issue resumes the next cycle with no lost or duplicated PC.
- redirect_valid with redirect_pc=0x40 while the queue holds 3 entries and a read is in flight → queue empties and the in-flight word is discarded. Next issue is 0x40 in R+1; out_valid with PC=0x40 in R+3.
- Redirect in the same cycle as pop and push with the queue full → redirect wins; count=0 next cycle.
- FETCH_BTFN_EN: BEQ with negative offset -8 at 0x10 → next issue 0x08; the 0x14 response is dropped; entry at 0x10 has pred_taken=1. Forward BEQ → pred_taken=0 and fetch continues sequentially.
- Reset asserted mid-stream with a read in flight → next cycle out_valid=0, count=0; the first issue after reset release is RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: IF/ID bundle and the opcodes the fetch predecoder needs.
// The fetch stage predecoder is enabled with FETCH_BTFN_EN.
package pipeline_pkg;

    localparam int PKG_XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] pc_plus4;
        logic [31:0]         instr;
        logic                pred_taken;
    } ifid_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue between imem responses and the IF/ID register.
// Holds PC, instruction and prediction bit per slot; PC+4 is rebuilt at the head.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter  int XLEN       = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int PW         = $clog2(FIFO_DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    input  logic            push_pred,
    input  logic            pop,
    output ifid_t           head,
    output logic            valid,
    output logic [CW-1:0]   count
);

    logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];
    logic [31:0]     instr_mem_q [FIFO_DEPTH];
    logic            pred_mem_q  [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: slots are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem_q[wr_ptr_q]    <= push_pc;
            instr_mem_q[wr_ptr_q] <= push_instr;
            pred_mem_q[wr_ptr_q]  <= push_pred;
        end
    end

    always_comb begin
        head.pc         = pc_mem_q[rd_ptr_q];
        head.pc_plus4   = pc_mem_q[rd_ptr_q] + XLEN'(4);
        head.instr      = instr_mem_q[rd_ptr_q];
        head.pred_taken = pred_mem_q[rd_ptr_q];
    end

    assign valid = (cnt_q != '0);
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-based imem issue, redirect and instruction queue.
// Define FETCH_BTFN_EN for static backward-taken/JAL-taken prediction.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              ADDR_WIDTH = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  id_ready,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic                  out_valid,
    output ifid_t                 outputs,
    output logic [XLEN-1:0]       PCPlus4F
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            squash_q, squash_d;

    logic [CW-1:0]   count;
    logic            issue;
    logic            push;
    logic            pop;
    logic            pred_take;
    logic [XLEN-1:0] pred_target;

`ifdef FETCH_BTFN_EN
    logic [6:0]      opcode;
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] b_imm;

    always_comb begin
        opcode = imem_rdata[6:0];
        j_imm  = XLEN'($signed({imem_rdata[31], imem_rdata[19:12],
                                imem_rdata[20], imem_rdata[30:21], 1'b0}));
        b_imm  = XLEN'($signed({imem_rdata[31], imem_rdata[7],
                                imem_rdata[30:25], imem_rdata[11:8], 1'b0}));
        pred_take = push && ((opcode == OP_JAL) ||
                             (opcode == OP_BRANCH && imem_rdata[31]));
        pred_target = inflight_pc_q + ((opcode == OP_JAL) ? j_imm : b_imm);
    end
`else
    assign pred_take   = 1'b0;
    assign pred_target = '0;
`endif

    // Credit counts queued entries plus the read still in flight.
    always_comb begin
        issue = !reset && !redirect_valid &&
                ((int'(count) + int'(inflight_q)) < FIFO_DEPTH);
        push  = inflight_q && !squash_q && !redirect_valid;
        pop   = out_valid && id_ready && !redirect_valid;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        squash_d      = pred_take && issue;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (pred_take) begin
            pc_d = pred_target;
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            squash_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            squash_q      <= squash_d;
        end
    end

    fetch_fifo #(
        .XLEN       (XLEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_valid),
        .push       (push),
        .push_pc    (inflight_pc_q),
        .push_instr (imem_rdata),
        .push_pred  (pred_take),
        .pop        (pop),
        .head       (outputs),
        .valid      (out_valid),
        .count      (count)
    );

    assign imem_req  = issue;
    assign imem_addr = pc_q[ADDR_WIDTH-1:0];
    assign PCPlus4F  = pc_q + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level fetch model.
// Directed prediction checks run only when FETCH_BTFN_EN is defined.
module tb_fetch_unit;
    import pipeline_pkg::*;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    ifid_t       outputs;
    logic [31:0] PCPlus4F;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic btfn_mode = 1'b0;

    // Every word fetched but not yet consumed by ID, oldest first.
    rec_t        q[$];
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .outputs        (outputs),
        .PCPlus4F       (PCPlus4F)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [7:0] a);
        if (btfn_mode && a == 8'h10) return 32'hFE000CE3;
        return {a ^ 8'h5A, a, ~a, 1'b0, 7'b0010011};
    endfunction

    always @(posedge clk) if (imem_req) imem_rdata <= instr_at(imem_addr);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic        exp_req;
        logic        exp_ov;
        logic [31:0] e4;
        logic [31:0] h4;
        @(negedge clk);
        if (reset) begin
            chk("req_in_reset", imem_req, 0);
            q.delete();
            exp_pc = 32'h0;
        end else begin
            exp_req = !redirect_valid && q.size() < 4;
            exp_ov  = q.size() > 0 && q[0].cyc <= cyc - 2;
            e4 = exp_pc + 32'd4;
            chk("imem_req", imem_req, exp_req);
            chk("pcplus4f", PCPlus4F, e4);
            if (exp_req) chk("imem_addr", imem_addr, exp_pc[7:0]);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                h4 = q[0].pc + 32'd4;
                chk("head_pc", outputs.pc, q[0].pc);
                chk("head_pc4", outputs.pc_plus4, h4);
                chk("head_instr", outputs.instr, instr_at(q[0].pc[7:0]));
                chk("head_pred", outputs.pred_taken, 0);
            end
            if (redirect_valid) begin
                q.delete();
                exp_pc = redirect_pc;
            end else begin
                if (exp_ov && id_ready) void'(q.pop_front());
                if (exp_req) begin
                    q.push_back('{exp_pc, cyc});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

`ifdef FETCH_BTFN_EN
    logic [7:0]  iss[$];
    logic [31:0] pcs[$];
    logic        preds[$];
`endif

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        // Stalled from reset: queue fills, issue stops at credit limit.
        id_ready = 1'b0;
        repeat (10) tick();
        id_ready = 1'b1;
        repeat (8) tick();
        // Redirect while fetching, then redirect against a full queue.
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        repeat (6) tick();
        id_ready = 1'b0;
        repeat (6) tick();
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: redirect_pc = 32'h40;
                1: redirect_pc = 32'hFFFF_FFF4;
                default: redirect_pc = $urandom & 32'hFFFF_FFFC;
            endcase
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        repeat (4) tick();
`ifdef FETCH_BTFN_EN
        btfn_mode = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (imem_req) iss.push_back(imem_addr);
            if (out_valid) begin
                pcs.push_back(outputs.pc);
                preds.push_back(outputs.pred_taken);
            end
            @(posedge clk);
            #1;
        end
        chk("btfn_len", (iss.size() >= 7 && pcs.size() >= 6), 1);
        if (iss.size() >= 7 && pcs.size() >= 6) begin
            chk("btfn_iss5", iss[5], 8'h14);
            chk("btfn_iss6", iss[6], 8'h08);
            chk("btfn_pc4", pcs[4], 32'h10);
            chk("btfn_pred4", preds[4], 1);
            chk("btfn_pc5", pcs[5], 32'h08);
            chk("btfn_pred5", preds[5], 0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
